// File: rtl/layer_seq_sched_if.sv
// Handshake bundle between the network host, the layer scheduler and
// the per-layer controllers. master: host side, slave: scheduler side.
interface layer_seq_sched_if #(
  parameter int NUM_LAYERS = 4,
  parameter int LID_W      = 5
);
  logic                  net_start;
  logic                  layer_done;
  logic [NUM_LAYERS-1:0] layer_start;
  logic                  layer_rst;
  logic [LID_W-1:0]      layer_id;
  logic                  bank_sel;
  logic                  busy;
  logic                  net_done;
  logic                  err;

  modport master (
    output net_start, layer_done,
    input  layer_start, layer_rst, layer_id,
    input  bank_sel, busy, net_done, err
  );

  modport slave (
    input  net_start, layer_done,
    output layer_start, layer_rst, layer_id,
    output bank_sel, busy, net_done, err
  );
endinterface

// File: rtl/layer_seq_sched.sv
// Network-level layer sequencer: launches layers in order, drains the
// address pipeline after each layer and flips the BRAM ping-pong bank.
// Ports: clk, rst (async, active-high), bus (layer_seq_sched_if.slave):
//   in  net_start, layer_done
//   out layer_start[NUM_LAYERS], layer_rst, layer_id, bank_sel,
//       busy, net_done, err
// Optional RUN watchdog: define LAYER_SEQ_WDOG_EN.
module layer_seq_sched #(
  parameter int NUM_LAYERS  = 4,
  parameter int LID_W       = 5,
  parameter int PIPE_DEPTH  = 5,
  parameter int WDOG_CYCLES = 4096,
  parameter int WDOG_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  layer_seq_sched_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DRAIN,
    S_SWAP
  } state_t;

  localparam int CNT_W =
    (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [LID_W-1:0] LAST_ID =
    LID_W'(NUM_LAYERS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD =
    CNT_W'(PIPE_DEPTH - 1);

  state_t           r_state, w_state_nxt;
  logic [LID_W-1:0] r_id, w_id_nxt;
  logic             r_bank, w_bank_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_done, w_done_nxt;
  logic [NUM_LAYERS-1:0] w_start;

`ifdef LAYER_SEQ_WDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST =
    WDOG_W'(WDOG_CYCLES - 1);
  logic              r_err, w_err_nxt;
  logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    w_bank_nxt  = r_bank;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
`ifdef LAYER_SEQ_WDOG_EN
    w_err_nxt   = r_err;
    w_wdog_nxt  = r_wdog;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (bus.net_start) begin
          w_state_nxt = S_LAUNCH;
          w_id_nxt    = '0;
          w_bank_nxt  = 1'b0;
`ifdef LAYER_SEQ_WDOG_EN
          w_err_nxt   = 1'b0;
`endif
        end
      end
      S_LAUNCH: begin
        w_state_nxt = S_RUN;
`ifdef LAYER_SEQ_WDOG_EN
        w_wdog_nxt  = '0;
`endif
      end
      S_RUN: begin
        if (bus.layer_done) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = DRAIN_LD;
        end
`ifdef LAYER_SEQ_WDOG_EN
        // Count value k-1 in the k-th RUN cycle.
        else if (r_wdog == WDOG_LAST) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_wdog_nxt  = r_wdog + WDOG_W'(1);
        end
`endif
      end
      S_DRAIN: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_SWAP;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      S_SWAP: begin
        // Output bank of this layer feeds the next one.
        w_bank_nxt = ~r_bank;
        if (r_id == LAST_ID) begin
          w_state_nxt = S_IDLE;
          w_id_nxt    = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_LAUNCH;
          w_id_nxt    = r_id + LID_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_bank  <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
      r_bank  <= w_bank_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef LAYER_SEQ_WDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err  <= 1'b0;
      r_wdog <= '0;
    end else begin
      r_err  <= w_err_nxt;
      r_wdog <= w_wdog_nxt;
    end
  end

  assign bus.err = r_err;
`else
  // Watchdog knobs have no hardware here; fold them into the tie-off.
  assign bus.err = (WDOG_CYCLES < 0) && (WDOG_W < 0);
`endif

  always_comb begin
    w_start = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_start[i] = (r_state == S_LAUNCH) &&
                   (r_id == LID_W'(i));
    end
  end

  // Decoded from state only, so rst forces layer_rst high at once.
  assign bus.layer_start = w_start;
  assign bus.layer_rst   = (r_state == S_IDLE) ||
                           (r_state == S_SWAP);
  assign bus.layer_id    = r_id;
  assign bus.bank_sel    = r_bank;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.net_done    = r_done;

endmodule

// File: tb/tb_layer_seq_sched.sv
// Scoreboard bench for layer_seq_sched: 3-layer and 1-layer instances,
// expected launches queued at stimulus time and checked at each start.
module tb_layer_seq_sched;
  localparam int NL = 3;
  localparam int LW = 5;
  localparam int PD = 5;
  localparam int WD = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_seq_sched_if #(.NUM_LAYERS(NL), .LID_W(LW)) bus ();
  layer_seq_sched_if #(.NUM_LAYERS(1), .LID_W(LW)) bus1 ();

  layer_seq_sched #(
    .NUM_LAYERS(NL), .LID_W(LW), .PIPE_DEPTH(PD),
    .WDOG_CYCLES(WD), .WDOG_W(16)
  ) u_dut (.clk(clk), .rst(rst), .bus(bus));

  layer_seq_sched #(
    .NUM_LAYERS(1), .LID_W(LW), .PIPE_DEPTH(PD),
    .WDOG_CYCLES(WD), .WDOG_W(16)
  ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [NL-1:0] start;
    logic          bank;
    logic [LW-1:0] id;
    int            gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_starts = 0;
  int n_done = 0;
  int last_cyc = 0;
  int st_cyc[64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.net_done) n_done++;
    if (!rst && bus.layer_start != '0) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_start: got %b at cycle %0d, required none",
                 bus.layer_start, cyc);
      end else begin
        m_e = exp_q.pop_front();
        if (bus.layer_start !== m_e.start || bus.bank_sel !== m_e.bank ||
            bus.layer_id !== m_e.id || bus.layer_rst !== 1'b0) begin
          n_fail++;
          $display("FAIL launch: got start=%b bank=%b id=%0d rst=%b, required start=%b bank=%b id=%0d rst=0",
                   bus.layer_start, bus.bank_sel, bus.layer_id, bus.layer_rst,
                   m_e.start, m_e.bank, m_e.id);
        end
        if (m_e.gap != 0) begin
          n_chk++;
          if (cyc - last_cyc != m_e.gap) begin
            n_fail++;
            $display("FAIL start_gap: got %0d, required %0d",
                     cyc - last_cyc, m_e.gap);
          end
        end
      end
      last_cyc = cyc;
      st_cyc[n_starts % 64] = cyc;
      n_starts++;
    end
  end

  task automatic pulse_start();
    bus.net_start = 1'b1;
    @(negedge clk);
    bus.net_start = 1'b0;
  endtask

  task automatic push_net(int dly);
    for (int i = 0; i < NL; i++) begin
      exp_t e;
      e.start = NL'(1 << i);
      e.bank  = i[0];
      e.id    = LW'(i);
      e.gap   = (i == 0) ? 0 : dly + PD + 2;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_nstart(int target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (n_starts >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL start_timeout: got %0d starts, required %0d",
               n_starts, target);
    end
  endtask

  task automatic drive_layers(int cnt, int dly, int hold,
                              bit inject, int base);
    bit ok;
    int st;
    for (int i = 0; i < cnt; i++) begin
      wait_nstart(base + i + 1, ok);
      if (!ok) return;
      st = st_cyc[(base + i) % 64];
      if (inject) begin
        while (cyc < st + 3) @(negedge clk);
        pulse_start();
      end
      while (cyc < st + dly) @(negedge clk);
      bus.layer_done = 1'b1;
      repeat (hold) @(negedge clk);
      bus.layer_done = 1'b0;
      if (inject) begin
        @(negedge clk);
        bus.layer_done = 1'b1;
        @(negedge clk);
        bus.layer_done = 1'b0;
      end
    end
  endtask

  task automatic finish_net(int d0, string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (n_done > d0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (!ok || n_done != d0 + 1) begin
      n_fail++;
      $display("FAIL %s_net_done: got %0d pulses, required 1", tag, n_done - d0);
    end
    n_chk++;
    if (bus.bank_sel !== 1'b1 || bus.busy !== 1'b0 ||
        bus.layer_rst !== 1'b1 || bus.layer_id !== '0) begin
      n_fail++;
      $display("FAIL %s_end_state: got bank=%b busy=%b rst=%b id=%0d, required 1 0 1 0",
               tag, bus.bank_sel, bus.busy, bus.layer_rst, bus.layer_id);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_starts: got %0d pending, required 0",
               tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_net(int dly, int hold, bit inject, string tag);
    int d0 = n_done;
    int base = n_starts;
    push_net(dly);
    pulse_start();
    drive_layers(NL, dly, hold, inject, base);
    finish_net(d0, tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.net_start = 1'b0;
    bus.layer_done = 1'b0;
    bus1.net_start = 1'b0;
    bus1.layer_done = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.layer_start !== '0 || bus.layer_rst !== 1'b1 ||
        bus.layer_id !== '0 || bus.bank_sel !== 1'b0 ||
        bus.busy !== 1'b0 || bus.net_done !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got start=%b rst=%b id=%0d bank=%b busy=%b done=%b err=%b, required 0 1 0 0 0 0 0",
               bus.layer_start, bus.layer_rst, bus.layer_id, bus.bank_sel,
               bus.busy, bus.net_done, bus.err);
    end
    n_chk++;
    if (bus1.layer_rst !== 1'b1 || bus1.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_single: got rst=%b busy=%b, required 1 0",
               bus1.layer_rst, bus1.busy);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sequence();
    run_net(10, 1, 1'b0, "seq");
  endtask

  task automatic test_ignore();
    int s0;
    run_net(10, 1, 1'b1, "ignore");
    s0 = n_starts;
    bus.layer_done = 1'b1;
    @(negedge clk);
    bus.layer_done = 1'b0;
    repeat (6) @(negedge clk);
    n_chk++;
    if (n_starts != s0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_done_ignored: got starts=%0d busy=%b, required %0d 0",
               n_starts, bus.busy, s0);
    end
  endtask

  task automatic test_hold();
    run_net(10, 8, 1'b0, "hold");
  endtask

  task automatic test_rst_mid();
    bit ok;
    int base = n_starts;
    push_net(10);
    pulse_start();
    drive_layers(1, 10, 1, 1'b0, base);
    wait_nstart(base + 2, ok);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (bus.layer_rst !== 1'b1 || bus.busy !== 1'b0 ||
        bus.layer_id !== '0 || bus.bank_sel !== 1'b0 ||
        bus.layer_start !== '0 || bus.net_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got rst=%b busy=%b id=%0d bank=%b start=%b done=%b, required 1 0 0 0 0 0",
               bus.layer_rst, bus.busy, bus.layer_id, bus.bank_sel,
               bus.layer_start, bus.net_done);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    run_net(10, 1, 1'b0, "restart");
  endtask

  task automatic test_back_to_back();
    int d0 = n_done;
    int base = n_starts;
    bit seen = 1'b0;
    push_net(10);
    pulse_start();
    drive_layers(NL, 10, 1, 1'b0, base);
    for (int k = 0; k < 100; k++) begin
      if (bus.net_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL b2b_first_done: got none, required pulse");
    end
    push_net(10);
    pulse_start();
    drive_layers(NL, 10, 1, 1'b0, base + NL);
    finish_net(d0 + 1, "b2b");
  endtask

  task automatic test_single();
    bit ok = 1'b0;
    bus1.net_start = 1'b1;
    @(negedge clk);
    bus1.net_start = 1'b0;
    n_chk++;
    if (bus1.layer_start !== 1'b1 || bus1.bank_sel !== 1'b0 ||
        bus1.layer_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL single_launch: got start=%b bank=%b rst=%b, required 1 0 0",
               bus1.layer_start, bus1.bank_sel, bus1.layer_rst);
    end
    repeat (3) @(negedge clk);
    bus1.layer_done = 1'b1;
    @(negedge clk);
    bus1.layer_done = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bus1.net_done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_chk++;
    if (!ok || bus1.bank_sel !== 1'b1 || bus1.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got done=%b bank=%b busy=%b, required 1 1 0",
               ok, bus1.bank_sel, bus1.busy);
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef LAYER_SEQ_WDOG_EN
  task automatic test_wdog();
    bit ok;
    int st;
    int d0 = n_done;
    int base = n_starts;
    push_net(10);
    pulse_start();
    wait_nstart(base + 1, ok);
    st = st_cyc[base % 64];
    while (cyc < st + WD) @(negedge clk);
    n_chk++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_early: got err=%b busy=%b, required 0 1",
               bus.err, bus.busy);
    end
    @(negedge clk);
    n_chk++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.layer_rst !== 1'b1 ||
        bus.bank_sel !== 1'b0 || bus.layer_id !== '0 || n_done != d0) begin
      n_fail++;
      $display("FAIL wdog_trip: got err=%b busy=%b rst=%b bank=%b id=%0d done=%0d, required 1 0 1 0 0 0",
               bus.err, bus.busy, bus.layer_rst, bus.bank_sel,
               bus.layer_id, n_done - d0);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    run_net(10, 1, 1'b0, "wdog_rerun");
    n_chk++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_clear: got err=%b, required 0", bus.err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_ignore();
    test_hold();
    test_rst_mid();
    test_back_to_back();
    test_single();
`ifdef LAYER_SEQ_WDOG_EN
    test_wdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
